// File: rtl/contador_4bits.sv
// Up/down counter with synchronous clear and parallel load, wrapping modulo 2^WIDTH.
// tc flags that the next step in the current direction wraps; zero flags an all-zero count.
module contador_4bits #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] entrada,
    output logic [WIDTH-1:0] contador,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] contador_q;
    logic [WIDTH-1:0] contador_d;

    // Load takes precedence over stepping; carry and borrow fall off the top bit.
    always_comb begin
        contador_d = contador_q;
        if (load) begin
            contador_d = entrada;
        end else if (up_down) begin
            contador_d = contador_q + CNT_ONE;
        end else begin
            contador_d = contador_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            contador_q <= CNT_ZERO;
        end else begin
            contador_q <= contador_d;
        end
    end

    assign contador = contador_q;
    assign zero     = (contador_q == CNT_ZERO);
    assign tc       = up_down ? (contador_q == CNT_MAX) : (contador_q == CNT_ZERO);

endmodule

// File: tb/tb_contador_4bits.sv
// Directed bench for contador_4bits: a modulo-16 arithmetic model checked every cycle,
// plus literal expectations taken from hand-worked sequences.
module tb_contador_4bits;

    logic       clock;
    logic       reset;
    logic       load;
    logic       up_down;
    logic [3:0] entrada;
    logic [3:0] contador;
    logic       tc;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    int exp_cnt     = 0;
    bit model_valid = 0;

    contador_4bits #(.WIDTH(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .up_down  (up_down),
        .entrada  (entrada),
        .contador (contador),
        .tc       (tc),
        .zero     (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: what the count must be after each edge, in plain integer arithmetic.
    always @(posedge clock) begin
        if (reset) begin
            exp_cnt     <= 0;
            model_valid <= 1'b1;
        end else if (load) begin
            exp_cnt <= int'(entrada);
        end else if (up_down) begin
            exp_cnt <= (exp_cnt + 1) % 16;
        end else begin
            exp_cnt <= (exp_cnt + 15) % 16;
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            checks = checks + 3;
            if (int'(contador) != exp_cnt) begin
                failures = failures + 1;
                $display("FAIL model_cnt t=%0t got=%0d exp=%0d", $time, contador, exp_cnt);
            end
            if (zero != (exp_cnt == 0)) begin
                failures = failures + 1;
                $display("FAIL model_zero t=%0t got=%0b exp=%0b", $time, zero, (exp_cnt == 0));
            end
            if (tc != (up_down ? (exp_cnt == 15) : (exp_cnt == 0))) begin
                failures = failures + 1;
                $display("FAIL model_tc t=%0t got=%0b exp=%0b up_down=%0b cnt=%0d",
                         $time, tc, (up_down ? (exp_cnt == 15) : (exp_cnt == 0)), up_down, exp_cnt);
            end
        end
    end

    // Drive controls, let one rising edge sample them, then settle just after the edge.
    task automatic apply(input logic r, input logic l, input logic ud, input logic [3:0] e);
        reset   = r;
        load    = l;
        up_down = ud;
        entrada = e;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_cnt(input string name, input logic [3:0] exp);
        checks = checks + 1;
        if (contador !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d exp=%0d", name, contador, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0b exp=%0b", name, act, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        up_down = 1'b1;
        entrada = 4'd0;

        // Reset for two edges, then count up from 0.
        apply(1, 0, 1, 0);
        apply(1, 0, 1, 0);
        chk_cnt("reset_cnt", 4'd0);
        chk_bit("reset_zero", zero, 1'b1);
        chk_bit("reset_tc_up", tc, 1'b0);
        apply(0, 0, 1, 0); chk_cnt("post_reset_1", 4'd1);
        apply(0, 0, 1, 0); chk_cnt("post_reset_2", 4'd2);
        apply(0, 0, 1, 0); chk_cnt("post_reset_3", 4'd3);

        // Up wrap.
        apply(0, 1, 1, 4'd14); chk_cnt("upwrap_14", 4'd14); chk_bit("upwrap_tc14", tc, 1'b0);
        apply(0, 0, 1, 0);     chk_cnt("upwrap_15", 4'd15); chk_bit("upwrap_tc15", tc, 1'b1);
        apply(0, 0, 1, 0);     chk_cnt("upwrap_0", 4'd0);   chk_bit("upwrap_zero", zero, 1'b1);
        chk_bit("upwrap_tc0", tc, 1'b0);
        apply(0, 0, 1, 0);     chk_cnt("upwrap_1", 4'd1);

        // Down wrap.
        apply(0, 1, 0, 4'd1); chk_cnt("dnwrap_1", 4'd1); chk_bit("dnwrap_tc1", tc, 1'b0);
        apply(0, 0, 0, 0);    chk_cnt("dnwrap_0", 4'd0);
        chk_bit("dnwrap_tc0", tc, 1'b1); chk_bit("dnwrap_zero", zero, 1'b1);
        apply(0, 0, 0, 0);    chk_cnt("dnwrap_15", 4'd15); chk_bit("dnwrap_tc15", tc, 1'b0);
        apply(0, 0, 0, 0);    chk_cnt("dnwrap_14", 4'd14);

        // Load wins over counting in both directions.
        apply(0, 1, 1, 4'd6);  chk_cnt("ldup_6", 4'd6);
        apply(0, 1, 1, 4'd10); chk_cnt("ldup_10", 4'd10);
        apply(0, 0, 1, 0);     chk_cnt("ldup_11", 4'd11);
        apply(0, 1, 1, 4'd6);  chk_cnt("lddn_6", 4'd6);
        apply(0, 1, 0, 4'd10); chk_cnt("lddn_10", 4'd10);
        apply(0, 0, 0, 0);     chk_cnt("lddn_9", 4'd9);

        // Reset wins over load; mid-count reset then resumes from 0.
        apply(1, 1, 1, 4'd5); chk_cnt("rst_over_load", 4'd0);
        apply(0, 1, 1, 4'd9); chk_cnt("midrst_9", 4'd9);
        apply(1, 0, 1, 0);    chk_cnt("midrst_0", 4'd0);
        apply(0, 0, 1, 0);    chk_cnt("midrst_1", 4'd1);

        // Direction change.
        apply(0, 1, 1, 4'd3); chk_cnt("dir_3", 4'd3);
        apply(0, 0, 1, 0);    chk_cnt("dir_4", 4'd4);
        apply(0, 0, 0, 0);    chk_cnt("dir_3b", 4'd3);
        apply(0, 0, 0, 0);    chk_cnt("dir_2", 4'd2);

        // tc follows up_down combinationally with no clock edge.
        apply(0, 1, 1, 4'd0); chk_bit("tcflip_0_up", tc, 1'b0);
        up_down = 1'b0; #1;   chk_bit("tcflip_0_dn", tc, 1'b1);
        apply(0, 1, 0, 4'd15); chk_bit("tcflip_15_dn", tc, 1'b0);
        up_down = 1'b1; #1;    chk_bit("tcflip_15_up", tc, 1'b1);
        load = 1'b0;

        // A load pulse that does not span a rising edge has no effect.
        apply(0, 0, 1, 0); chk_cnt("glitch_pre", 4'd0);
        load = 1'b1; entrada = 4'd7; #2; load = 1'b0;
        @(posedge clock); #1; chk_cnt("glitch_post", 4'd1);

        // Random tail against the model.
        for (int i = 0; i < 60; i++) begin
            apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
